board_memory: RTL and testbench

Game board storage and win/tie detector. It sits directly downstream of the game controller FSM.
- Consumes the controller's per-cycle write request (addr, cellState).
- Holds the 9-cell board.
- Feeds back gBoard, gameIsDone and winner to the controller.
- Win detection is serial: one winning line is checked per cycle after each accepted move.

---
 rtl/board_memory_pkg.sv | 41 ++++
 rtl/board_memory_win_line_rom.sv | 26 ++
 rtl/board_memory.sv | 144 ++++++++++++++
 tb/tb_board_memory.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_memory_pkg.sv
// Types and constants shared by the game controller and the board memory.
// Cell encoding and winner codes line up so a winning cell value is also its winner code.
package board_memory_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int BOARD_W   = 2 * NUM_CELLS;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b10,
        CELL_O     = 2'b11
    } cell_state_t;

    typedef enum logic [1:0] {
        NO_WIN = 2'b00,
        TIE    = 2'b01,
        WIN_X  = 2'b10,
        WIN_O  = 2'b11
    } winner_t;

    localparam logic [3:0] NO_WRITE_ADDR = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } board_state_t;

    // Indices outside 0..8 read as EMPTY so callers need no range guard.
    function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] board,
                                           input logic [3:0] idx);
        logic [1:0] val;
        val = CELL_EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == 4'(i)) val = board[2*i +: 2];
        end
        return val;
    endfunction

endpackage

// File: rtl/board_memory_win_line_rom.sv
// Maps a winning-line index to its three cell indices: rows, then columns, then diagonals.
module win_line_rom (
    input  logic [2:0] line_idx,
    output logic [3:0] cell_a,
    output logic [3:0] cell_b,
    output logic [3:0] cell_c
);

    always_comb begin
        cell_a = 4'd0;
        cell_b = 4'd1;
        cell_c = 4'd2;
        case (line_idx)
            3'd0: begin cell_a = 4'd0; cell_b = 4'd1; cell_c = 4'd2; end
            3'd1: begin cell_a = 4'd3; cell_b = 4'd4; cell_c = 4'd5; end
            3'd2: begin cell_a = 4'd6; cell_b = 4'd7; cell_c = 4'd8; end
            3'd3: begin cell_a = 4'd0; cell_b = 4'd3; cell_c = 4'd6; end
            3'd4: begin cell_a = 4'd1; cell_b = 4'd4; cell_c = 4'd7; end
            3'd5: begin cell_a = 4'd2; cell_b = 4'd5; cell_c = 4'd8; end
            3'd6: begin cell_a = 4'd0; cell_b = 4'd4; cell_c = 4'd8; end
            3'd7: begin cell_a = 4'd2; cell_b = 4'd4; cell_c = 4'd6; end
            default: begin cell_a = 4'd0; cell_b = 4'd1; cell_c = 4'd2; end
        endcase
    end

endmodule

// File: rtl/board_memory.sv
// Board storage with a serial win/tie scanner: one winning line is checked per cycle
// after each accepted move. Writes are only accepted in IDLE; anything else is dropped.
module board_memory
    import board_memory_pkg::*;
(
    input  logic                ph1,
    input  logic                reset,
    input  logic                newGame,
    input  logic [3:0]          addr,
    input  logic [1:0]          cellState,
    output logic [BOARD_W-1:0]  gBoard,
    output logic                gameIsDone,
    output logic [1:0]          winner,
    output logic                busy,
    output logic                writeRejected,
    output logic [3:0]          moveCount
);

    board_state_t       state_q, state_d;
    logic [2:0]         line_idx_q, line_idx_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [3:0]         move_count_q, move_count_d;
    logic               done_q, done_d;
    winner_t            winner_q, winner_d;
    logic               busy_q, busy_d;
    logic               rejected_q, rejected_d;

    logic [3:0] idx_a, idx_b, idx_c;
    logic [1:0] val_a, val_b, val_c;
    logic       line_win;
    logic       write_req;
    logic       write_legal;

    win_line_rom u_win_line_rom (
        .line_idx (line_idx_q),
        .cell_a   (idx_a),
        .cell_b   (idx_b),
        .cell_c   (idx_c)
    );

    assign val_a    = cell_at(board_q, idx_a);
    assign val_b    = cell_at(board_q, idx_b);
    assign val_c    = cell_at(board_q, idx_c);
    assign line_win = (val_a != CELL_EMPTY) && (val_a == val_b) && (val_b == val_c);

    assign write_req   = (addr != NO_WRITE_ADDR);
    assign write_legal = (addr <= 4'd8) && (cell_at(board_q, addr) == CELL_EMPTY)
                         && (cellState != CELL_EMPTY);

    always_comb begin
        state_d      = state_q;
        line_idx_d   = line_idx_q;
        board_d      = board_q;
        move_count_d = move_count_q;
        done_d       = done_q;
        winner_d     = winner_q;
        busy_d       = busy_q;
        rejected_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (write_req) begin
                    if (write_legal) begin
                        for (int i = 0; i < NUM_CELLS; i++) begin
                            if (addr == 4'(i)) board_d[2*i +: 2] = cellState;
                        end
                        if (move_count_q != 4'(NUM_CELLS)) move_count_d = move_count_q + 4'd1;
                        line_idx_d = 3'd0;
                        state_d    = SCAN;
                        busy_d     = 1'b1;
                    end else begin
                        rejected_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                rejected_d = write_req;
                // The win check comes first so a ninth-move win reports the player.
                if (line_win) begin
                    state_d  = DONE;
                    winner_d = winner_t'(val_a);
                    done_d   = 1'b1;
                end else if (line_idx_q != 3'(NUM_LINES - 1)) begin
                    line_idx_d = line_idx_q + 3'd1;
                end else if (move_count_q == 4'(NUM_CELLS)) begin
                    state_d  = DONE;
                    winner_d = TIE;
                    done_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                rejected_d = write_req;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new game silently swallows any write presented alongside it.
        if (newGame) begin
            state_d      = IDLE;
            line_idx_d   = 3'd0;
            board_d      = '0;
            move_count_d = 4'd0;
            done_d       = 1'b0;
            winner_d     = NO_WIN;
            busy_d       = 1'b0;
            rejected_d   = 1'b0;
        end
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q      <= IDLE;
            line_idx_q   <= 3'd0;
            board_q      <= '0;
            move_count_q <= 4'd0;
            done_q       <= 1'b0;
            winner_q     <= NO_WIN;
            busy_q       <= 1'b0;
            rejected_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_idx_q   <= line_idx_d;
            board_q      <= board_d;
            move_count_q <= move_count_d;
            done_q       <= done_d;
            winner_q     <= winner_d;
            busy_q       <= busy_d;
            rejected_q   <= rejected_d;
        end
    end

    assign gBoard        = board_q;
    assign gameIsDone    = done_q;
    assign winner        = winner_q;
    assign busy          = busy_q;
    assign writeRejected = rejected_q;
    assign moveCount     = move_count_q;

endmodule

// File: tb/tb_board_memory.sv
// Bench for board_memory: a driver issues moves and pushes the reference model's
// per-cycle expected outputs; a monitor pops and compares one entry per clock edge.
module tb_board_memory;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic        newGame = 1'b0;
    logic [3:0]  addr = 4'hf;
    logic [1:0]  cellState = 2'b00;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic [1:0]  winner;
    logic        busy;
    logic        writeRejected;
    logic [3:0]  moveCount;

    always #5 ph1 = ~ph1;

    board_memory dut (
        .ph1           (ph1),
        .reset         (reset),
        .newGame       (newGame),
        .addr          (addr),
        .cellState     (cellState),
        .gBoard        (gBoard),
        .gameIsDone    (gameIsDone),
        .winner        (winner),
        .busy          (busy),
        .writeRejected (writeRejected),
        .moveCount     (moveCount)
    );

    typedef struct packed {
        logic [17:0] board;
        logic        done;
        logic [1:0]  winner;
        logic        busy;
        logic        rej;
        logic [3:0]  moves;
    } out_t;

    out_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    string phase = "reset";

    // Reference model: board as an array, result and its latency computed up front
    // from the line order (win on line k after k+1 edges, otherwise after 8 edges).
    int m_board[9];
    int m_moves = 0;
    bit m_done = 0;
    int m_winner = 0;
    int m_count = 0;
    bit m_pend_done = 0;
    int m_pend_winner = 0;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic model_step(input bit clr, input int a, input int c, output out_t o);
        bit rej;
        rej = 1'b0;
        if (clr) begin
            foreach (m_board[i]) m_board[i] = 0;
            m_moves = 0;
            m_done = 0;
            m_winner = 0;
            m_count = 0;
        end else if (m_count > 0) begin
            rej = (a != 15);
            m_count--;
            if (m_count == 0 && m_pend_done) begin
                m_done = 1;
                m_winner = m_pend_winner;
            end
        end else if (m_done) begin
            rej = (a != 15);
        end else if (a != 15) begin
            if (a <= 8 && m_board[a] == 0 && c != 0) begin
                m_board[a] = c;
                m_moves++;
                m_pend_done = 0;
                m_count = 8;
                for (int k = 0; k < 8; k++) begin
                    if (m_board[lines[k][0]] != 0 &&
                        m_board[lines[k][0]] == m_board[lines[k][1]] &&
                        m_board[lines[k][1]] == m_board[lines[k][2]]) begin
                        m_count = k + 1;
                        m_pend_done = 1;
                        m_pend_winner = m_board[lines[k][0]];
                        break;
                    end
                end
                if (!m_pend_done && m_moves == 9) begin
                    m_pend_done = 1;
                    m_pend_winner = 1;
                end
            end else begin
                rej = 1'b1;
            end
        end
        o.board = '0;
        for (int i = 0; i < 9; i++) o.board[2*i +: 2] = 2'(m_board[i]);
        o.done   = m_done;
        o.winner = 2'(m_winner);
        o.busy   = (m_count > 0) || m_done;
        o.rej    = rej;
        o.moves  = 4'(m_moves);
    endtask

    task automatic cycle(input bit r, input bit ng, input int a, input int c);
        out_t e;
        @(negedge ph1);
        reset     = r;
        newGame   = ng;
        addr      = 4'(a);
        cellState = 2'(c);
        model_step(r || ng, a, c, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 15, 0);
    endtask

    // Issue one move, then idle until the scan it triggers has finished.
    task automatic move(input int a, input int c);
        cycle(1'b0, 1'b0, a, c);
        while (m_count > 0) idle(1);
    endtask

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s [%s] got %0h expected %0h at %0t", name, phase, act, exp, $time);
    endfunction

    initial begin : monitor
        out_t e;
        forever begin
            @(posedge ph1);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gBoard", int'(gBoard), int'(e.board));
                check("gameIsDone", int'(gameIsDone), int'(e.done));
                check("winner", int'(winner), int'(e.winner));
                check("busy", int'(busy), int'(e.busy));
                check("writeRejected", int'(writeRejected), int'(e.rej));
                check("moveCount", int'(moveCount), int'(e.moves));
            end
        end
    end

    initial begin : driver
        int r, ar, cr, a, c;
        repeat (3) cycle(1'b1, 1'b0, 15, 0);
        phase = "idle";
        idle(20);

        phase = "o_top_row";
        cycle(1'b0, 1'b1, 15, 0);
        move(0, 3); move(3, 2); move(1, 3); move(4, 2); move(2, 3);
        idle(4);

        phase = "x_anti_diag";
        cycle(1'b0, 1'b1, 15, 0);
        move(2, 2); move(0, 3); move(4, 2); move(1, 3); move(6, 2);
        idle(3);

        phase = "tie";
        cycle(1'b0, 1'b1, 15, 0);
        move(0, 3); move(1, 2); move(2, 3); move(4, 2); move(3, 3);
        move(5, 2); move(7, 3); move(6, 2); move(8, 3);
        idle(3);

        phase = "rejects";
        cycle(1'b0, 1'b1, 15, 0);
        move(4, 3);
        cycle(1'b0, 1'b0, 4, 2);
        cycle(1'b0, 1'b0, 9, 3);
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 14, 2);
        idle(1);
        cycle(1'b0, 1'b0, 0, 3);
        idle(2);
        cycle(1'b0, 1'b0, 1, 2);
        while (m_count > 0) idle(1);
        move(1, 2); move(8, 3);
        cycle(1'b0, 1'b0, 5, 2);
        idle(3);

        phase = "reset_in_done";
        cycle(1'b1, 1'b0, 15, 0);
        idle(2);

        phase = "newgame_mid_scan";
        cycle(1'b0, 1'b0, 0, 3);
        idle(3);
        cycle(1'b0, 1'b1, 5, 2);
        idle(3);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 199);
            ar = $urandom_range(0, 19);
            cr = $urandom_range(0, 5);
            a  = (ar > 15) ? 15 : ar;
            c  = (cr == 0) ? 0 : ((cr <= 2) ? 2 : 3);
            cycle(r == 0, (r >= 1 && r <= 3), a, c);
        end
        idle(2);

        phase = "drain";
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge ph1);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
